// File: rtl/fir_p2s_unpacker.sv
// rtl/fir_p2s_unpacker.sv - 3-lane parallel to serial unpacker with triplet FIFO.
// Optional SAMPLE_CNT output enabled by defining P2S_SAMPLE_CNT_EN.
module fir_p2s_unpacker #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] DIN0,
  input  logic [W-1:0] DIN1,
  input  logic [W-1:0] DIN2,
  input  logic         VIN,
  output logic         IN_READY,
  output logic [W-1:0] DOUT,
  output logic         VOUT,
  input  logic         DOUT_READY,
  output logic         OVF
`ifdef P2S_SAMPLE_CNT_EN
  ,
  output logic [15:0]  SAMPLE_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3*W-1:0] mem_q [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     lane_q, lane_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           vout_q, vout_d;
  logic           ovf_q, ovf_d;

  logic           push, drop, out_free, load, pop;
  logic [3*W-1:0] head;
  logic [W-1:0]   lane_sel;

  // Ready is decoded from the registered count only; a same-cycle pop does not free a slot.
  assign IN_READY = (count_q < CW'(DEPTH));
  assign push     = VIN && IN_READY;
  assign drop     = VIN && !IN_READY;
  assign out_free = !vout_q || DOUT_READY;
  assign load     = out_free && (count_q != '0);
  assign pop      = load && (lane_q == 2'd2);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    lane_sel = head[W-1:0];
    case (lane_q)
      2'd1:    lane_sel = head[2*W-1:W];
      2'd2:    lane_sel = head[3*W-1:2*W];
      default: lane_sel = head[W-1:0];
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    dout_d   = dout_q;
    vout_d   = vout_q;
    lane_d   = lane_q;
    rd_ptr_d = rd_ptr_q;
    if (load) begin
      dout_d = lane_sel;
      vout_d = 1'b1;
      if (lane_q == 2'd2) begin
        lane_d   = 2'd0;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end else if (out_free) begin
      vout_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {DIN2, DIN1, DIN0};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= 2'd0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign OVF  = ovf_q;

`ifdef P2S_SAMPLE_CNT_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;

  assign sample_cnt_d = (vout_q && DOUT_READY) ? sample_cnt_q + 16'd1 : sample_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sample_cnt_q <= 16'd0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign SAMPLE_CNT = sample_cnt_q;
`endif

endmodule

// File: tb/tb_fir_p2s_unpacker.sv
// tb/tb_fir_p2s_unpacker.sv - scoreboard bench for fir_p2s_unpacker.
// Covers the P2S_SAMPLE_CNT_EN counter when that macro is defined.
module tb_fir_p2s_unpacker;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] DIN0 = '0, DIN1 = '0, DIN2 = '0;
  logic         VIN = 1'b0;
  logic         IN_READY;
  logic [W-1:0] DOUT;
  logic         VOUT;
  logic         DOUT_READY = 1'b0;
  logic         OVF;
`ifdef P2S_SAMPLE_CNT_EN
  logic [15:0]  SAMPLE_CNT;
`endif

  fir_p2s_unpacker #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN0       (DIN0),
    .DIN1       (DIN1),
    .DIN2       (DIN2),
    .VIN        (VIN),
    .IN_READY   (IN_READY),
    .DOUT       (DOUT),
    .VOUT       (VOUT),
    .DOUT_READY (DOUT_READY),
    .OVF        (OVF)
`ifdef P2S_SAMPLE_CNT_EN
    ,
    .SAMPLE_CNT (SAMPLE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Scoreboard of samples still to be accepted, and model queue of samples not yet presented.
  logic [W-1:0] sb[$];
  logic [W-1:0] mq[$];
  bit           vout_m = 1'b0;
  bit           ovf_m  = 1'b0;
  logic [15:0]  cnt_m  = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts what the coming edge does.
  task automatic step(input bit vin, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input bit rdy);
    int occ;
    @(negedge CLK);
    #1;
    occ = (mq.size() + 2) / 3;
    chk("in_ready", 32'(IN_READY), 32'(occ < DEPTH));
    chk("vout", 32'(VOUT), 32'(vout_m));
    chk("ovf", 32'(OVF), 32'(ovf_m));
    VIN = vin; DIN0 = a; DIN1 = b; DIN2 = c; DOUT_READY = rdy;
    if (!vout_m || rdy) begin
      if (occ > 0) begin
        void'(mq.pop_front());
        vout_m = 1'b1;
      end else begin
        vout_m = 1'b0;
      end
    end
    if (vin) begin
      if (occ < DEPTH) begin
        mq.push_back(a); mq.push_back(b); mq.push_back(c);
        sb.push_back(a); sb.push_back(b); sb.push_back(c);
      end else begin
        ovf_m = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_vout", 32'(VOUT), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    mq.delete(); sb.delete();
    vout_m = 1'b0; ovf_m = 1'b0; cnt_m = 16'd0;
    VIN = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
  endtask

  // Monitor: compares every accepted sample against the scoreboard and checks hold stability.
  bit           hold_prev = 1'b0;
  logic [W-1:0] prev_dout = '0;
  initial begin
    forever begin
      @(negedge CLK);
      #3;
      if (RST) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) chk("hold_dout", 32'(DOUT), 32'(prev_dout));
`ifdef P2S_SAMPLE_CNT_EN
        chk("sample_cnt", 32'(SAMPLE_CNT), 32'(cnt_m));
`endif
        if (VOUT && DOUT_READY) begin
          if (sb.size() == 0) chk("unexpected_sample", 32'(DOUT), 32'hFFFF_FFFF);
          else chk("dout", 32'(DOUT), 32'(sb.pop_front()));
          cnt_m = cnt_m + 16'd1;
        end
        hold_prev = VOUT && !DOUT_READY;
        prev_dout = DOUT;
      end
    end
  end

  initial begin
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("reset_dout", 32'(DOUT), 32'd0);
    chk("reset_vout", 32'(VOUT), 32'd0);
    chk("reset_ovf", 32'(OVF), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd1);

    // Single triplet
    step(1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
    idle(6, 1'b1);

    // Back-pressure hold
    step(1'b1, 8'hA0, 8'hA1, 8'hA2, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Continuous streaming, one triplet every third cycle
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 8'(3*k), 8'(3*k+1), 8'(3*k+2), 1'b1);
      idle(2, 1'b1);
    end
    idle(5, 1'b1);

    // Pointer wrap: six triplets spaced two cycles apart with random back-pressure
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'(8'hC0 + 3*k), 8'(8'hC1 + 3*k), 8'(8'hC2 + 3*k), 1'($urandom_range(0, 1)));
      step(1'b0, '0, '0, '0, 1'($urandom_range(0, 1)));
    end
    idle(30, 1'b1);

    // Fill and overflow
    for (int n = 0; n < 6; n++) step(1'b1, 8'(3*n), 8'(3*n+1), 8'(3*n+2), 1'b0);
    idle(20, 1'b1);
    chk("ovf_sticky", 32'(OVF), 32'd1);

    // Reset with two buffered triplets and VOUT high
    step(1'b1, 8'h51, 8'h52, 8'h53, 1'b0);
    step(1'b1, 8'h54, 8'h55, 8'h56, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);
    do_reset();
    idle(8, 1'b1);

`ifdef P2S_SAMPLE_CNT_EN
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'(8'h70 + 3*k), 8'(8'h71 + 3*k), 8'(8'h72 + 3*k), 1'b1);
      step(1'b0, '0, '0, '0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      step(1'b0, '0, '0, '0, 1'b0);
    end
    #1;
    chk("sample_cnt_nine", 32'(SAMPLE_CNT), 32'd9);
    for (int k = 0; k < 21846; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      idle(2, 1'b1);
    end
    idle(5, 1'b1);
    #1;
    chk("sample_cnt_wrap", 32'(SAMPLE_CNT), 32'd11);
`endif

    // Randomized traffic with random back-pressure and occasional overflow
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    idle(30, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
